ks_adder_pipe: RTL

//   Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready flow control.

---
 rtl/ks_adder_pipe.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: parametrised Kogge-Stone adder/subtractor with optional
// register cuts between prefix levels, an always-registered output stage,
// valid/ready flow control and a tag sideband.
//
// Carry-in is folded into the prefix network as an extra generate bit at
// position 0. Bit j of the network then represents operand bit j-1, so after
// the last level g[j] is the carry into operand bit j. The network stays
// WIDTH bits wide. Carry-out is rebuilt in the output stage from the MSB
// generate/propagate and the carry into the MSB.
module ks_adder_pipe #(
  parameter int          WIDTH     = 16,
  parameter logic [31:0] PIPE_MASK = 32'b0101,
  parameter int          TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Global advance enable: every stage moves together, or all of them hold.
  logic en;

  // Operand conditioning and initial generate/propagate vectors.
  logic [WIDTH-1:0] s0_bop;
  logic [WIDTH-1:0] s0_h;
  logic [WIDTH-1:0] s0_g;
  logic [WIDTH-1:0] s0_p;

  assign s0_bop = in_sub ? ~in_b : in_b;
  assign s0_h   = in_a ^ s0_bop;
  // Position 0 carries cin as a pure generate (its propagate is 0).
  assign s0_g   = {in_a[WIDTH-2:0] & s0_bop[WIDTH-2:0], in_cin};
  assign s0_p   = {s0_h[WIDTH-2:0], 1'b0};

  // Prefix levels. Each level either passes its result straight on or
  // registers it, depending on the corresponding PIPE_MASK bit.
  for (genvar gi = 0; gi < LEVELS; gi++) begin : g_lvl
    localparam int SPAN = 1 << gi;

    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] h_in;
    logic [TAG_W-1:0] t_in;
    logic             am_in;
    logic             bm_in;
    logic             v_in;

    logic [WIDTH-1:0] g_d;
    logic [WIDTH-1:0] p_d;

    logic [WIDTH-1:0] g_o;
    logic [WIDTH-1:0] p_o;
    logic [WIDTH-1:0] h_o;
    logic [TAG_W-1:0] t_o;
    logic             am_o;
    logic             bm_o;
    logic             v_o;

    if (gi == 0) begin : g_src
      assign g_in  = s0_g;
      assign p_in  = s0_p;
      assign h_in  = s0_h;
      assign t_in  = in_tag;
      assign am_in = in_a[WIDTH-1];
      assign bm_in = s0_bop[WIDTH-1];
      assign v_in  = in_valid;
    end else begin : g_chain
      assign g_in  = g_lvl[gi-1].g_o;
      assign p_in  = g_lvl[gi-1].p_o;
      assign h_in  = g_lvl[gi-1].h_o;
      assign t_in  = g_lvl[gi-1].t_o;
      assign am_in = g_lvl[gi-1].am_o;
      assign bm_in = g_lvl[gi-1].bm_o;
      assign v_in  = g_lvl[gi-1].v_o;
    end

    // Kogge-Stone combine with the neighbour SPAN positions below. Shifted-in
    // zeros leave the low positions' G unchanged; their P becomes 0, which is
    // correct because those groups already reach the cin position.
    assign g_d = g_in | (p_in & (g_in << SPAN));
    assign p_d = p_in & (p_in << SPAN);

    if (PIPE_MASK[gi]) begin : g_cut
      logic [WIDTH-1:0] g_q;
      logic [WIDTH-1:0] p_q;
      logic [WIDTH-1:0] h_q;
      logic [TAG_W-1:0] t_q;
      logic             am_q;
      logic             bm_q;
      logic             v_q;

      // Stage valid: cleared by reset, otherwise advances with the pipeline.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q <= 1'b0;
        end else if (en) begin
          v_q <= v_in;
        end
      end

      // Stage payload: no reset needed, qualified by v_q downstream.
      always_ff @(posedge clk) begin
        if (en) begin
          g_q  <= g_d;
          p_q  <= p_d;
          h_q  <= h_in;
          t_q  <= t_in;
          am_q <= am_in;
          bm_q <= bm_in;
        end
      end

      assign g_o  = g_q;
      assign p_o  = p_q;
      assign h_o  = h_q;
      assign t_o  = t_q;
      assign am_o = am_q;
      assign bm_o = bm_q;
      assign v_o  = v_q;
    end else begin : g_pass
      assign g_o  = g_d;
      assign p_o  = p_d;
      assign h_o  = h_in;
      assign t_o  = t_in;
      assign am_o = am_in;
      assign bm_o = bm_in;
      assign v_o  = v_in;
    end
  end

  // Final prefix results feeding the output stage.
  logic [WIDTH-1:0] fin_g;
  logic [WIDTH-1:0] fin_h;
  logic [TAG_W-1:0] fin_t;
  logic             fin_am;
  logic             fin_bm;
  logic             fin_v;
  logic             unused_fin_p;

  assign fin_g  = g_lvl[LEVELS-1].g_o;
  assign fin_h  = g_lvl[LEVELS-1].h_o;
  assign fin_t  = g_lvl[LEVELS-1].t_o;
  assign fin_am = g_lvl[LEVELS-1].am_o;
  assign fin_bm = g_lvl[LEVELS-1].bm_o;
  assign fin_v  = g_lvl[LEVELS-1].v_o;
  // Group propagate of the last level is not needed for the sum.
  assign unused_fin_p = ^g_lvl[LEVELS-1].p_o;

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  // fin_g[j] is the carry into operand bit j (cin at j = 0).
  assign sum_d  = fin_h ^ fin_g;
  assign cout_d = (fin_am & fin_bm) | (fin_h[WIDTH-1] & fin_g[WIDTH-1]);
  assign ovf_d  = (fin_am == fin_bm) && (sum_d[WIDTH-1] != fin_am);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic [TAG_W-1:0] out_tag_q;

  // The pipeline may advance when the output register is empty or retiring.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Output register: cleared by reset; payload only reloaded by a valid beat
  // so the outputs stay quiet across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_tag_q   <= '0;
    end else if (en) begin
      out_valid_q <= fin_v;
      if (fin_v) begin
        out_sum_q  <= sum_d;
        out_cout_q <= cout_d;
        out_ovf_q  <= ovf_d;
        out_tag_q  <= fin_t;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_tag   = out_tag_q;

endmodule
